// File: rtl/rnn_mem_responder.sv
// Memory/input responder for the RNN core: host-loaded weight banks, output capture, input stream.
// Optional protocol-error checking is enabled by defining RNN_MEM_ERR_EN.
module rnn_mem_responder #(
  parameter int unsigned IN_DEPTH = 32,
  parameter int unsigned OUT_AW   = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              busy_i,
  input  logic              i_en_i,
  input  logic              mce_i,
  input  logic [2:0]        msel_i,
  input  logic [16:0]       maddr_i,
  input  logic [19:0]       mdata_w_i,
  output logic [19:0]       mdata_r_o,
  output logic [31:0]       idata_o,
  output logic              ready_o,
  input  logic              start_i,
  input  logic              ld_en_i,
  input  logic [2:0]        ld_sel_i,
  input  logic [16:0]       ld_addr_i,
  input  logic [31:0]       ld_data_i,
  input  logic [OUT_AW-1:0] rd_addr_i,
  output logic [19:0]       rd_data_o,
  output logic              done_o,
  output logic [OUT_AW:0]   wr_count_o,
  output logic              err_o
);

  localparam int unsigned IPW       = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int unsigned OUT_DEPTH = 1 << OUT_AW;

  typedef enum logic [1:0] {StIdle, StReady, StRun, StDone} state_e;

  state_e            state_q;
  logic              ready_q, done_q;
  logic [IPW-1:0]    iptr_q;
  logic [OUT_AW:0]   wr_count_q;
  logic [19:0]       t_q;

  logic [19:0] w_ih     [2048];
  logic [19:0] b_ih     [64];
  logic [19:0] w_hh     [4096];
  logic [19:0] b_hh     [64];
  logic [19:0] out_bank [OUT_DEPTH];
  logic [31:0] in_mem   [IN_DEPTH];

  logic           host_ok, ld_we, core_we, in_adv;
  logic [IPW-1:0] ld_iaddr;
  logic           unused_maddr;

  assign host_ok  = (state_q == StIdle) || (state_q == StDone);
  assign ld_we    = ld_en_i && host_ok;
  assign core_we  = mce_i && (msel_i == 3'b101);
  assign in_adv   = i_en_i && ((state_q == StReady) || (state_q == StRun));
  assign ld_iaddr = IPW'(ld_addr_i % 17'(IN_DEPTH));
  assign unused_maddr = ^maddr_i[16:12];

  // Bank contents deliberately survive reset; only the header register is cleared.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      case (ld_sel_i)
        3'b000:  w_ih[ld_addr_i[10:0]]  <= ld_data_i[19:0];
        3'b001:  b_ih[ld_addr_i[5:0]]   <= ld_data_i[19:0];
        3'b010:  w_hh[ld_addr_i[11:0]]  <= ld_data_i[19:0];
        3'b011:  b_hh[ld_addr_i[5:0]]   <= ld_data_i[19:0];
        3'b110:  in_mem[ld_iaddr]       <= ld_data_i;
        default: ;
      endcase
    end
    if (core_we) out_bank[maddr_i[OUT_AW-1:0]] <= mdata_w_i;
  end

  always_ff @(posedge clk) begin
    if (reset)                               t_q <= '0;
    else if (ld_we && (ld_sel_i == 3'b100))  t_q <= ld_data_i[19:0];
  end

  always_comb begin
    mdata_r_o = '0;
    if (mce_i) begin
      case (msel_i)
        3'b000:  mdata_r_o = w_ih[maddr_i[10:0]];
        3'b001:  mdata_r_o = b_ih[maddr_i[5:0]];
        3'b010:  mdata_r_o = w_hh[maddr_i[11:0]];
        3'b011:  mdata_r_o = b_hh[maddr_i[5:0]];
        3'b100:  mdata_r_o = t_q;
        default: mdata_r_o = '0;
      endcase
    end
  end

  assign idata_o    = in_mem[iptr_q];
  assign rd_data_o  = out_bank[rd_addr_i];
  assign ready_o    = ready_q;
  assign done_o     = done_q;
  assign wr_count_o = wr_count_q;

  // Later assignments in the state case override the pointer/counter updates on a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      iptr_q     <= '0;
      wr_count_q <= '0;
    end else begin
      if (in_adv) iptr_q <= (iptr_q == IPW'(IN_DEPTH - 1)) ? '0 : iptr_q + 1'b1;
      if (core_we && (wr_count_q != '1)) wr_count_q <= wr_count_q + 1'b1;
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q    <= StReady;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            iptr_q     <= '0;
            wr_count_q <= '0;
          end
        end
        StReady: begin
          if (busy_i) begin
            state_q <= StRun;
            ready_q <= 1'b0;
          end
        end
        StRun: begin
          if (!busy_i) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef RNN_MEM_ERR_EN
  logic err_q, err_hit;

  always_comb begin
    err_hit = 1'b0;
    if (mce_i) begin
      case (msel_i)
        3'b000:         err_hit = maddr_i > 17'd2047;
        3'b001, 3'b011: err_hit = maddr_i > 17'd63;
        3'b010:         err_hit = maddr_i > 17'd4095;
        3'b101:         err_hit = (state_q != StRun) || (maddr_i >= 17'(OUT_DEPTH)) ||
                                  (wr_count_q == '1);
        3'b110, 3'b111: err_hit = 1'b1;
        default:        err_hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        err_q <= 1'b0;
    else if (err_hit) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
